// File: rtl/scnn_sparse_conv_4pe.sv
// scnn_sparse_conv_4pe: SCNN-style sparse 2-D convolution, 4 PEs scatter-accumulating nonzero act x weight products.
// Optional macro SCNN_RELU_EN clamps negative reduced sums to zero.
module scnn_sparse_conv_4pe #(
    parameter int PARAM_IP_SIZE = 64,
    parameter int PARAM_WT_SIZE = 25,
    parameter int PARAM_IP_DIM  = 8,
    parameter int PARAM_WT_DIM  = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PARAM_IP_SIZE-1:0][15:0] input_acts,
    input  logic [7:0]                     input_dim,
    input  logic [PARAM_WT_SIZE-1:0][15:0] weights,
    input  logic [3:0]                     weight_dim,
    output logic [PARAM_IP_SIZE-1:0][31:0] outputs
);
    localparam int IW  = $clog2(PARAM_IP_SIZE);
    localparam int WIW = $clog2(PARAM_WT_SIZE);
    localparam int AW  = $clog2(PARAM_IP_SIZE + 1);
    localparam int WW  = $clog2(PARAM_WT_SIZE + 1);
    localparam int TW  = AW + WW;
    localparam int DW  = $clog2(PARAM_IP_DIM + 1);
    localparam int KW  = $clog2(PARAM_WT_DIM + 1);
    localparam int CW  = $clog2(PARAM_IP_DIM);
    localparam int RW  = $clog2(PARAM_WT_DIM);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MULT, S_REDUCE} state_t;

    state_t                        state_q, state_d;
    logic [DW-1:0]                 dim_q, dim_d, dim_c, h;
    logic [KW-1:0]                 kdim_q, kdim_d, kdim_c;
    logic signed [15:0]            av_q [4][PARAM_IP_SIZE];
    logic signed [15:0]            av_d [4][PARAM_IP_SIZE];
    logic [CW-1:0]                 ay_q [4][PARAM_IP_SIZE];
    logic [CW-1:0]                 ay_d [4][PARAM_IP_SIZE];
    logic [CW-1:0]                 ax_q [4][PARAM_IP_SIZE];
    logic [CW-1:0]                 ax_d [4][PARAM_IP_SIZE];
    logic [AW-1:0]                 na_q [4];
    logic [AW-1:0]                 na_d [4];
    logic signed [15:0]            wv_q [PARAM_WT_SIZE];
    logic signed [15:0]            wv_d [PARAM_WT_SIZE];
    logic [RW-1:0]                 wr_q [PARAM_WT_SIZE];
    logic [RW-1:0]                 wr_d [PARAM_WT_SIZE];
    logic [RW-1:0]                 ws_q [PARAM_WT_SIZE];
    logic [RW-1:0]                 ws_d [PARAM_WT_SIZE];
    logic [WW-1:0]                 nw_q, nw_d, wi_q, wi_d;
    logic [AW-1:0]                 ai_q, ai_d, mx;
    logic [TW-1:0]                 cnt_q, cnt_d, tot_q, tot_d;
    logic signed [31:0]            ps_q [4][PARAM_IP_SIZE];
    logic signed [31:0]            ps_d [4][PARAM_IP_SIZE];
    logic [PARAM_IP_SIZE-1:0][31:0] outputs_q, outputs_d;
    logic [1:0]                    pe;
    logic [IW-1:0]                 fi;
    logic [WIW-1:0]                fw;
    logic signed [31:0]            pr, sum;
    int                            oy, ox, kp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dim_q     <= '0;
            kdim_q    <= '0;
            av_q      <= '{default: '0};
            ay_q      <= '{default: '0};
            ax_q      <= '{default: '0};
            na_q      <= '{default: '0};
            wv_q      <= '{default: '0};
            wr_q      <= '{default: '0};
            ws_q      <= '{default: '0};
            nw_q      <= '0;
            wi_q      <= '0;
            ai_q      <= '0;
            cnt_q     <= '0;
            tot_q     <= '0;
            ps_q      <= '{default: '0};
            outputs_q <= '0;
        end else begin
            state_q   <= state_d;
            dim_q     <= dim_d;
            kdim_q    <= kdim_d;
            av_q      <= av_d;
            ay_q      <= ay_d;
            ax_q      <= ax_d;
            na_q      <= na_d;
            wv_q      <= wv_d;
            wr_q      <= wr_d;
            ws_q      <= ws_d;
            nw_q      <= nw_d;
            wi_q      <= wi_d;
            ai_q      <= ai_d;
            cnt_q     <= cnt_d;
            tot_q     <= tot_d;
            ps_q      <= ps_d;
            outputs_q <= outputs_d;
        end
    end

    // Sequencing, dim clamping and compression of the dense inputs into per-PE nonzero lists.
    always_comb begin
        state_d = state_q;
        dim_d   = dim_q;
        kdim_d  = kdim_q;
        av_d    = av_q;
        ay_d    = ay_q;
        ax_d    = ax_q;
        na_d    = na_q;
        wv_d    = wv_q;
        wr_d    = wr_q;
        ws_d    = ws_q;
        nw_d    = nw_q;
        wi_d    = wi_q;
        ai_d    = ai_q;
        cnt_d   = cnt_q;
        tot_d   = tot_q;
        pe      = '0;
        fi      = '0;
        fw      = '0;
        mx      = '0;
        dim_c   = (input_dim > 8'(PARAM_IP_DIM)) ? DW'(PARAM_IP_DIM) :
                  (input_dim == '0) ? DW'(1) : input_dim[DW-1:0];
        kdim_c  = (weight_dim > 4'(PARAM_WT_DIM)) ? KW'(PARAM_WT_DIM) :
                  (weight_dim == '0) ? KW'(1) : weight_dim[KW-1:0];
        h       = DW'((int'(dim_c) + 1) >> 1);
        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_MULT;
                dim_d   = dim_c;
                kdim_d  = kdim_c;
                av_d    = '{default: '0};
                ay_d    = '{default: '0};
                ax_d    = '{default: '0};
                na_d    = '{default: '0};
                wv_d    = '{default: '0};
                wr_d    = '{default: '0};
                ws_d    = '{default: '0};
                nw_d    = '0;
                for (int y = 0; y < PARAM_IP_DIM; y++) begin
                    for (int x = 0; x < PARAM_IP_DIM; x++) begin
                        fi = IW'(y * int'(dim_c) + x);
                        pe = {DW'(y) >= h, DW'(x) >= h};
                        if (DW'(y) < dim_c && DW'(x) < dim_c && input_acts[fi] != '0) begin
                            av_d[pe][IW'(na_d[pe])] = input_acts[fi];
                            ay_d[pe][IW'(na_d[pe])] = CW'(y);
                            ax_d[pe][IW'(na_d[pe])] = CW'(x);
                            na_d[pe] = na_d[pe] + AW'(1);
                        end
                    end
                end
                for (int r = 0; r < PARAM_WT_DIM; r++) begin
                    for (int s = 0; s < PARAM_WT_DIM; s++) begin
                        fw = WIW'(r * int'(kdim_c) + s);
                        if (KW'(r) < kdim_c && KW'(s) < kdim_c && weights[fw] != '0) begin
                            wv_d[WIW'(nw_d)] = weights[fw];
                            wr_d[WIW'(nw_d)] = RW'(r);
                            ws_d[WIW'(nw_d)] = RW'(s);
                            nw_d = nw_d + WW'(1);
                        end
                    end
                end
                for (int p = 0; p < 4; p++)
                    mx = (na_d[p] > mx) ? na_d[p] : mx;
                tot_d = TW'(mx) * TW'(nw_d);
                tot_d = (tot_d == '0) ? TW'(1) : tot_d;
                cnt_d = '0;
                ai_d  = '0;
                wi_d  = '0;
            end
            S_MULT: begin
                state_d = (cnt_q == tot_q - TW'(1)) ? S_REDUCE : S_MULT;
                cnt_d   = cnt_q + TW'(1);
                wi_d    = (wi_q + WW'(1) >= nw_q) ? '0 : wi_q + WW'(1);
                ai_d    = (wi_q + WW'(1) >= nw_q) ? ai_q + AW'(1) : ai_q;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // All PEs share the (act, weight) cursor; a PE whose list is exhausted simply skips.
    always_comb begin
        ps_d = ps_q;
        pr   = '0;
        oy   = 0;
        ox   = 0;
        kp   = int'(kdim_q - KW'(1)) >> 1;
        if (state_q == S_LOAD)
            ps_d = '{default: '0};
        else if (state_q == S_MULT)
            for (int p = 0; p < 4; p++) begin
                if (ai_q < na_q[p] && wi_q < nw_q) begin
                    oy = int'(ay_q[p][IW'(ai_q)]) - int'(wr_q[WIW'(wi_q)]) + kp;
                    ox = int'(ax_q[p][IW'(ai_q)]) - int'(ws_q[WIW'(wi_q)]) + kp;
                    pr = av_q[p][IW'(ai_q)] * wv_q[WIW'(wi_q)];
                    if (oy >= 0 && oy < int'(dim_q) && ox >= 0 && ox < int'(dim_q))
                        ps_d[p][IW'(oy * int'(dim_q) + ox)] = ps_q[p][IW'(oy * int'(dim_q) + ox)] + pr;
                end
            end
    end

    always_comb begin
        outputs_d = outputs_q;
        sum       = '0;
        if (state_q == S_REDUCE)
            for (int i = 0; i < PARAM_IP_SIZE; i++) begin
                sum = ps_q[0][i] + ps_q[1][i] + ps_q[2][i] + ps_q[3][i];
`ifdef SCNN_RELU_EN
                sum = sum[31] ? '0 : sum;
`endif
                outputs_d[i] = (i < int'(dim_q) * int'(dim_q)) ? sum : '0;
            end
    end

    assign outputs = outputs_q;

endmodule

// File: tb/tb_scnn_sparse_conv_4pe.sv
// tb_scnn_sparse_conv_4pe: directed vectors against a plain-arithmetic convolution model, checked every cycle.
module tb_scnn_sparse_conv_4pe;
`ifdef SCNN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [63:0][15:0] input_acts;
    logic [7:0]        input_dim;
    logic [24:0][15:0] weights;
    logic [3:0]        weight_dim;
    logic [63:0][31:0] outputs;

    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                exp_cyc = 0;
    int                bad;
    bit                cmp_en = 1'b0;
    logic [63:0][31:0] exp_plane;
    logic [63:0][31:0] want;

    always #5 clk = ~clk;

    scnn_sparse_conv_4pe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .input_acts (input_acts),
        .input_dim  (input_dim),
        .weights    (weights),
        .weight_dim (weight_dim),
        .outputs    (outputs)
    );

    function automatic logic [31:0] rl(input logic signed [31:0] v);
        return (RELU && v < 0) ? 32'd0 : v;
    endfunction

    // Direct convolution over the dense plane; pass length from per-quadrant nonzero counts.
    function automatic void model(output logic [63:0][31:0] pl, output int n);
        int d, k, p, h, nw, mx, oy, ox;
        int na [4];
        logic signed [31:0] acc [64];
        d  = (int'(input_dim) > 8) ? 8 : (input_dim == 0) ? 1 : int'(input_dim);
        k  = (int'(weight_dim) > 5) ? 5 : (weight_dim == 0) ? 1 : int'(weight_dim);
        p  = (k - 1) / 2;
        h  = (d + 1) / 2;
        nw = 0;
        mx = 0;
        for (int i = 0; i < 4; i++) na[i] = 0;
        for (int i = 0; i < 64; i++) acc[i] = 0;
        for (int i = 0; i < k * k; i++) if (weights[i] != 0) nw++;
        for (int y = 0; y < d; y++)
            for (int x = 0; x < d; x++) begin
                if (input_acts[y * d + x] == 0) continue;
                na[(y >= h ? 2 : 0) + (x >= h ? 1 : 0)]++;
                for (int r = 0; r < k; r++)
                    for (int s = 0; s < k; s++) begin
                        oy = y - r + p;
                        ox = x - s + p;
                        if (oy >= 0 && oy < d && ox >= 0 && ox < d)
                            acc[oy * d + ox] += $signed(input_acts[y * d + x]) * $signed(weights[r * k + s]);
                    end
            end
        for (int i = 0; i < 4; i++) if (na[i] > mx) mx = na[i];
        n = (mx * nw > 1) ? mx * nw : 1;
        for (int i = 0; i < 64; i++) pl[i] = (i < d * d) ? rl(acc[i]) : 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic clr(input int d, input int k);
        input_acts = '0;
        weights    = '0;
        input_dim  = 8'(d);
        weight_dim = 4'(k);
    endtask

    task automatic run_case(output int n);
        @(negedge clk);
        rst_n  = 1'b0;
        cmp_en = 1'b0;
        model(exp_plane, n);
        exp_cyc = 3 + n;
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (2 * exp_cyc + 2) @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    // Outputs stay zero until the first reduce edge, then hold the model plane.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            want = (cyc >= exp_cyc) ? exp_plane : '0;
            checks++;
            if (outputs !== want) begin
                failures++;
                bad = 0;
                for (int i = 63; i >= 0; i--) if (outputs[i] !== want[i]) bad = i;
                $display("FAIL plane cyc=%0d idx=%0d got=%h want=%h", cyc, bad, outputs[bad], want[bad]);
            end
        end
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        exp_plane  = '0;
        input_dim  = 8'd8;
        weight_dim = 4'd3;
        for (int i = 0; i < 64; i++) input_acts[i] = 16'h1234 + 16'(i);
        for (int i = 0; i < 25; i++) weights[i] = 16'h0007;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_hold_out27", outputs[27], 32'd0);
        chk("reset_hold_any", {31'd0, |outputs}, 32'd0);

        clr(8, 3); input_acts[9] = 16'd3; weights[4] = 16'd2;
        run_case(n);
        chk("centre_out9", outputs[9], 32'd6);
        chk("centre_pass", 32'(3 + n), 32'd4);

        clr(8, 3); input_acts[9] = 16'd3; weights[0] = 16'd5;
        run_case(n);
        chk("offset_out18", outputs[18], 32'd15);
        chk("offset_out9", outputs[9], 32'd0);

        clr(8, 3); input_acts[0] = 16'd4; weights[8] = 16'd1;
        run_case(n);
        chk("edge_drop_any", {31'd0, |outputs}, 32'd0);

        clr(8, 3); input_acts[27] = 16'd1; input_acts[36] = 16'd1; weights[4] = 16'd1; weights[8] = 16'd1;
        run_case(n);
        chk("xpe_out27", outputs[27], 32'd2);
        chk("xpe_out18", outputs[18], 32'd1);
        chk("xpe_out36", outputs[36], 32'd1);
        chk("xpe_pass", 32'(3 + n), 32'd5);

        for (int i = 0; i < 40 && cyc != 15; i++) begin
            @(posedge clk);
            #2;
        end
        chk("mid_reach_mult", 32'(cyc), 32'd15);
        chk("mid_before_out27", outputs[27], 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_after_out27", outputs[27], 32'd0);
        chk("mid_after_any", {31'd0, |outputs}, 32'd0);
        run_case(n);
        chk("mid_restart_out27", outputs[27], 32'd2);

        clr(8, 3); input_acts[36] = 16'hFFFE; weights[4] = 16'd3;
        run_case(n);
        chk("signed_out36", outputs[36], RELU ? 32'd0 : 32'hFFFFFFFA);

        clr(8, 3);
        run_case(n);
        chk("zero_pass", 32'(3 + n), 32'd4);
        chk("zero_any", {31'd0, |outputs}, 32'd0);

        clr(5, 3);
        input_acts[0] = 16'd1; input_acts[6] = 16'd2; input_acts[13] = 16'd5;
        input_acts[24] = 16'hFFFF; input_acts[30] = 16'd9;
        weights[1] = 16'd1; weights[4] = 16'd2; weights[5] = 16'hFFFD; weights[20] = 16'd7;
        run_case(n);
        chk("odd_out6", outputs[6], 32'd4);
        chk("odd_out12", outputs[12], RELU ? 32'd0 : 32'hFFFFFFF1);
        chk("odd_out30_beyond", outputs[30], 32'd0);
        chk("odd_pass", 32'(3 + n), 32'd9);

        clr(12, 0);
        input_acts[63] = 16'd7; input_acts[0] = 16'd100; weights[0] = 16'hFFFE; weights[1] = 16'd5;
        run_case(n);
        chk("sat_out63", outputs[63], RELU ? 32'd0 : 32'hFFFFFFF2);
        chk("sat_out0", outputs[0], RELU ? 32'd0 : 32'hFFFFFF38);
        chk("sat_pass", 32'(3 + n), 32'd4);

        clr(2, 2);
        for (int i = 0; i < 4; i++) input_acts[i] = 16'h8000;
        for (int i = 0; i < 3; i++) weights[i] = 16'h8000;
        run_case(n);
        chk("wrap_out0", outputs[0], RELU ? 32'd0 : 32'hC0000000);
        chk("wrap_out1", outputs[1], RELU ? 32'd0 : 32'h80000000);
        chk("wrap_out3", outputs[3], 32'h40000000);
        chk("wrap_pass", 32'(3 + n), 32'd6);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
